// File: rtl/instr_sequencer.sv
// Program-side sequencer for bit_serial: loadable instruction store, program counter,
// start/done handshake, and PC advance on the processor's increment strobe.
module instr_sequencer #(
  parameter int INSTR_W = 3,
  parameter int PC_W    = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_prog_we,
  input  logic [PC_W-1:0]    i_prog_addr,
  input  logic [INSTR_W-1:0] i_prog_data,
  input  logic [PC_W-1:0]    i_data_last,
  input  logic               i_run,
  input  logic               i_con_pcincr,
  output logic [INSTR_W-1:0] o_data_instruction,
  output logic               o_start,
  output logic [PC_W-1:0]    o_data_pc,
  output logic               o_con_busy,
  output logic               o_con_done
);

  localparam int DEPTH = 2 ** PC_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r;
  logic [PC_W-1:0]    pc_r;
  logic [PC_W-1:0]    last_r;
  logic               start_r;
  logic               busy_r;
  logic               done_r;
  logic [INSTR_W-1:0] store_r [DEPTH];

  // Instruction store: writable only while idle so a running program cannot be altered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        store_r[i] <= '0;
      end
    end else if (i_prog_we && (state_r == IDLE)) begin
      store_r[i_prog_addr] <= i_prog_data;
    end
  end

  // Sequencing FSM with registered handshake outputs and program counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      pc_r    <= '0;
      last_r  <= '0;
      start_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          pc_r   <= '0;
          done_r <= 1'b0;
          if (i_run) begin
            state_r <= START;
            last_r  <= i_data_last;
            start_r <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        START: begin
          state_r <= RUN;
          start_r <= 1'b0;
          busy_r  <= 1'b1;
        end
        RUN: begin
          if (i_con_pcincr) begin
            if (pc_r != last_r) begin
              pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
            end else begin
              // Last instruction retired: pc stays put for the done cycle
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          pc_r    <= '0;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          pc_r    <= '0;
          start_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data_instruction = store_r[pc_r];
  assign o_data_pc          = pc_r;
  assign o_start            = start_r;
  assign o_con_busy         = busy_r;
  assign o_con_done         = done_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: each driven cycle queues its expected outputs,
// which are popped and compared once the DUT has updated after the clock edge.
module tb_instr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       prog_we;
  logic [1:0] prog_addr;
  logic [2:0] prog_data;
  logic [1:0] data_last;
  logic       run;
  logic       pcincr;
  logic [2:0] instr;
  logic       start;
  logic [1:0] pc;
  logic       busy;
  logic       done;

  int total;
  int bad;

  typedef struct {
    string      tag;
    logic [1:0] pc;
    logic [2:0] instr;
    logic       start;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  instr_sequencer #(.INSTR_W(3), .PC_W(2)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_prog_we          (prog_we),
    .i_prog_addr        (prog_addr),
    .i_prog_data        (prog_data),
    .i_data_last        (data_last),
    .i_run              (run),
    .i_con_pcincr       (pcincr),
    .o_data_instruction (instr),
    .o_start            (start),
    .o_data_pc          (pc),
    .o_con_busy         (busy),
    .o_con_done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drive current inputs for one edge, queue the expected post-edge outputs, then score them
  task automatic step(input string tag, input logic [1:0] e_pc, input logic [2:0] e_instr,
                      input logic e_start, input logic e_busy, input logic e_done);
    exp_t e;
    exp_t o;
    e.tag = tag; e.pc = e_pc; e.instr = e_instr;
    e.start = e_start; e.busy = e_busy; e.done = e_done;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o = exp_q.pop_front();
    check_val({o.tag, ".pc"},    32'(pc),    32'(o.pc));
    check_val({o.tag, ".instr"}, 32'(instr), 32'(o.instr));
    check_val({o.tag, ".start"}, 32'(start), 32'(o.start));
    check_val({o.tag, ".busy"},  32'(busy),  32'(o.busy));
    check_val({o.tag, ".done"},  32'(done),  32'(o.done));
    @(negedge clk);
    prog_we = 1'b0;
    run     = 1'b0;
    pcincr  = 1'b0;
  endtask

  task automatic write_store(input logic [1:0] a, input logic [2:0] d,
                             input logic [1:0] e_pc, input logic [2:0] e_instr);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step("wr", e_pc, e_instr, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = 2'd0; prog_data = 3'd0;
    data_last = 2'd0; run = 1'b0; pcincr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.pc",    32'(pc),    32'd0);
    check_val("rst.instr", 32'(instr), 32'd0);
    check_val("rst.busy",  32'(busy),  32'd0);
    check_val("rst.start", 32'(start), 32'd0);
    check_val("rst.done",  32'(done),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Program {000,110,000,000}, last=2
    write_store(2'd0, 3'b000, 2'd0, 3'b000);
    write_store(2'd1, 3'b110, 2'd0, 3'b000);
    write_store(2'd2, 3'b000, 2'd0, 3'b000);
    pcincr = 1'b1;
    step("idle_incr", 2'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    run = 1'b1; data_last = 2'd2;
    step("p1_start", 2'd0, 3'b000, 1'b1, 1'b1, 1'b0);
    pcincr = 1'b1;
    step("p1_start_incr", 2'd0, 3'b000, 1'b0, 1'b1, 1'b0);
    pcincr = 1'b1;
    step("p1_pc1", 2'd1, 3'b110, 1'b0, 1'b1, 1'b0);
    step("p1_hold", 2'd1, 3'b110, 1'b0, 1'b1, 1'b0);
    pcincr = 1'b1;
    step("p1_pc2", 2'd2, 3'b000, 1'b0, 1'b1, 1'b0);
    pcincr = 1'b1;
    step("p1_done", 2'd2, 3'b000, 1'b0, 1'b0, 1'b1);
    step("p1_idle", 2'd0, 3'b000, 1'b0, 1'b0, 1'b0);

    // Single-instruction program, last=0
    write_store(2'd0, 3'b101, 2'd0, 3'b101);
    run = 1'b1; data_last = 2'd0;
    step("p2_start", 2'd0, 3'b101, 1'b1, 1'b1, 1'b0);
    step("p2_run", 2'd0, 3'b101, 1'b0, 1'b1, 1'b0);
    pcincr = 1'b1;
    step("p2_done", 2'd0, 3'b101, 1'b0, 1'b0, 1'b1);
    step("p2_idle", 2'd0, 3'b101, 1'b0, 1'b0, 1'b0);

    // Write and run attempts during RUN are ignored; held pcincr counts each cycle
    run = 1'b1; data_last = 2'd3;
    step("p3_start", 2'd0, 3'b101, 1'b1, 1'b1, 1'b0);
    step("p3_run", 2'd0, 3'b101, 1'b0, 1'b1, 1'b0);
    prog_we = 1'b1; prog_addr = 2'd1; prog_data = 3'b111; run = 1'b1;
    step("p3_ign", 2'd0, 3'b101, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      pcincr = 1'b1;
      step($sformatf("p3_held%0d", i), 2'(i), (i == 1) ? 3'b110 : 3'b000, 1'b0, 1'b1, 1'b0);
    end
    pcincr = 1'b1;
    step("p3_done", 2'd3, 3'b000, 1'b0, 1'b0, 1'b1);
    step("p3_idle", 2'd0, 3'b101, 1'b0, 1'b0, 1'b0);

    // Last latched at start: changing it mid-run has no effect
    run = 1'b1; data_last = 2'd2;
    step("p4_start", 2'd0, 3'b101, 1'b1, 1'b1, 1'b0);
    data_last = 2'd0;
    step("p4_run", 2'd0, 3'b101, 1'b0, 1'b1, 1'b0);
    pcincr = 1'b1;
    step("p4_pc1", 2'd1, 3'b110, 1'b0, 1'b1, 1'b0);
    pcincr = 1'b1;
    step("p4_pc2", 2'd2, 3'b000, 1'b0, 1'b1, 1'b0);
    pcincr = 1'b1; run = 1'b1;
    step("p4_done", 2'd2, 3'b000, 1'b0, 1'b0, 1'b1);
    run = 1'b1; data_last = 2'd2;
    step("p4_idle", 2'd0, 3'b101, 1'b0, 1'b0, 1'b0);
    run = 1'b1;
    step("p5_restart", 2'd0, 3'b101, 1'b1, 1'b1, 1'b0);
    step("p5_run", 2'd0, 3'b101, 1'b0, 1'b1, 1'b0);
    pcincr = 1'b1;
    step("p5_pc1", 2'd1, 3'b110, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-RUN at pc=1
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst.pc",    32'(pc),    32'd0);
    check_val("arst.busy",  32'(busy),  32'd0);
    check_val("arst.start", 32'(start), 32'd0);
    check_val("arst.instr", 32'(instr), 32'd0);
    check_val("arst.done",  32'(done),  32'd0);
    pcincr = 1'b1;
    @(posedge clk);
    #1;
    check_val("arst.done2", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pcincr = 1'b0;
    step("post_rst", 2'd0, 3'b000, 1'b0, 1'b0, 1'b0);

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
